// File: rtl/dram_responder_pkg.sv
// Shared types and helpers for the backing-store responder at the far end of
// the LLC lower-level interface.
package dram_responder_pkg;

    localparam int unsigned DRAM_W          = 64;
    localparam int unsigned DRAM_LINE_BYTES = 64;
    localparam int unsigned DRAM_WORDS      = 4096;
    localparam int unsigned DRAM_LATENCY    = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LAT,
        BURST
    } dram_state_t;

    // Byte address of the start of the line containing addr.
    function automatic logic [DRAM_W-1:0] line_base(input logic [DRAM_W-1:0] addr,
                                                    input int unsigned       line_bits);
        return addr & ~((DRAM_W'(1) << line_bits) - DRAM_W'(1));
    endfunction

    // Word number of addr; callers keep only the low index bits so that
    // out-of-range addresses wrap onto the array.
    function automatic logic [DRAM_W-1:0] word_index(input logic [DRAM_W-1:0] addr,
                                                     input int unsigned       off_bits);
        return addr >> off_bits;
    endfunction

endpackage

// File: rtl/dram_word_array.sv
// Single-port word store: synchronous write, combinational read, no reset.
module dram_word_array #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk_in,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dram_responder.sv
// Backing-store responder: word writes, line reads returned as a burst of
// words after a fixed latency.
module dram_responder
    import dram_responder_pkg::*;
#(
    parameter int unsigned W         = DRAM_W,
    parameter int unsigned B         = DRAM_LINE_BYTES,
    parameter int unsigned MEM_WORDS = DRAM_WORDS,
    parameter int unsigned LATENCY   = DRAM_LATENCY
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         hc_valid_in,
    output logic         hc_ready_out,
    input  logic [W-1:0] hc_addr_in,
    input  logic [W-1:0] hc_value_in,
    input  logic         hc_we_in,
    output logic         hc_valid_out,
    input  logic         hc_ready_in,
    output logic [W-1:0] hc_addr_out,
    output logic [W-1:0] hc_value_out
);

    localparam int unsigned WORD_BYTES    = W / 8;
    localparam int unsigned BEATS         = B / WORD_BYTES;
    localparam int unsigned WORD_IDX_BITS = $clog2(MEM_WORDS);
    localparam int unsigned OFF_BITS      = $clog2(WORD_BYTES);
    localparam int unsigned LINE_BITS     = $clog2(B);
    localparam int unsigned LAT_W         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned BEAT_W        = (BEATS > 1) ? $clog2(BEATS) : 1;

    dram_state_t        state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [W-1:0]       base_q, base_d;
    logic               valid_d, ready_d;
    logic [W-1:0]       addr_d, value_d;

    logic                     mem_we_c;
    logic [W-1:0]             rd_addr_c;
    logic [WORD_IDX_BITS-1:0] mem_idx_c;
    logic [W-1:0]             mem_rdata_c;

    // Writes happen only in IDLE, reads only outside it, so one port suffices.
    dram_word_array #(
        .W     (W),
        .DEPTH (MEM_WORDS)
    ) u_array (
        .clk_in (clk_in),
        .we     (mem_we_c),
        .addr   (mem_idx_c),
        .wdata  (hc_value_in),
        .rdata  (mem_rdata_c)
    );

    assign mem_idx_c = WORD_IDX_BITS'(word_index(DRAM_W'(rd_addr_c), OFF_BITS));

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        base_d    = base_q;
        valid_d   = hc_valid_out;
        addr_d    = hc_addr_out;
        value_d   = hc_value_out;
        mem_we_c  = 1'b0;
        rd_addr_c = hc_addr_out + W'(WORD_BYTES);

        case (state_q)
            IDLE: begin
                rd_addr_c = hc_addr_in;
                if (hc_valid_in && hc_ready_out) begin
                    if (hc_we_in) begin
                        mem_we_c = 1'b1;
                    end else begin
                        base_d  = W'(line_base(DRAM_W'(hc_addr_in), LINE_BITS));
                        lat_d   = LAT_W'(LATENCY - 1);
                        beat_d  = '0;
                        state_d = WAIT_LAT;
                    end
                end
            end
            WAIT_LAT: begin
                rd_addr_c = base_q;
                if (lat_q == '0) begin
                    state_d = BURST;
                    valid_d = 1'b1;
                    addr_d  = base_q;
                    value_d = mem_rdata_c;
                    beat_d  = '0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            BURST: begin
                if (hc_valid_out && hc_ready_in) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        addr_d  = rd_addr_c;
                        value_d = mem_rdata_c;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            beat_q       <= '0;
            base_q       <= '0;
            hc_valid_out <= 1'b0;
            hc_addr_out  <= '0;
            hc_value_out <= '0;
            hc_ready_out <= 1'b1;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            hc_valid_out <= valid_d;
            hc_addr_out  <= addr_d;
            hc_value_out <= value_d;
            hc_ready_out <= ready_d;
        end
    end

endmodule

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Backing-store responder at the lowest level of the memory subsystem; it is the far end of the LLC's lower-level (lc_*) interface.
- Accepts word writes and line-read requests from the cache over a valid/ready request channel.
- After a fixed latency, returns a read line as a burst of W-bit words over a valid/ready response channel.
- Writes never produce a response.

Parameters:
- W, 64, word width in bits (address and data)
- B, 64, line size in bytes; must be a multiple of W/8
- MEM_WORDS, 4096, backing-store depth in W-bit words; power of two
- LATENCY, 4, cycles from read acceptance to first response beat; must be at least 1

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous, active-high reset
- hc_valid_in  input  1  cache presents a request
- hc_ready_out  output  1  responder can accept a request
- hc_addr_in  input  W  byte address of request
- hc_value_in  input  W  write data
- hc_we_in  input  1  1 = word write, 0 = line read
- hc_valid_out  output  1  response beat valid
- hc_ready_in  input  1  cache accepts response beat
- hc_addr_out  output  W  byte address of the word in this beat
- hc_value_out  output  W  data of this beat

Behaviour:
- Derived constants: WORD_BYTES = W/8; BEATS = B/WORD_BYTES; WORD_IDX_BITS = log2(MEM_WORDS).
- Transfer rule: a transfer occurs on a posedge where valid and ready are both 1.
  - Valid, addr and value must hold until the transfer.
  - The responder never drops hc_valid_out or changes hc_addr_out / hc_value_out before its beat transfers.
- Reset (rst_in=1 at posedge):
  - State becomes IDLE.
  - hc_valid_out=0, hc_addr_out=0, hc_value_out=0, hc_ready_out=1 from the following cycle.
  - Beat and latency counters are cleared.
  - Memory contents are not cleared.
  - Reset mid-burst or mid-latency aborts the read. No further beats are produced for it.
- All outputs are registered. hc_ready_out is 1 only in IDLE.
- States:
  - IDLE
    - Write accepted: mem[word index] <= hc_value_in. Word index = hc_addr_in[log2(WORD_BYTES) +: WORD_IDX_BITS]; the low log2(WORD_BYTES) bits are ignored. State stays IDLE and ready stays 1, so back-to-back writes run at one per cycle.
    - Read accepted: latch base = hc_addr_in with the low log2(B) bits forced to 0, load lat_cnt = LATENCY-1, and go to WAIT_LAT.
  - WAIT_LAT
    - Decrement lat_cnt each cycle.
    - When lat_cnt==0, go to BURST with beat 0 registered: hc_valid_out=1, hc_addr_out=base, hc_value_out=mem[index(base)].
    - Net effect: acceptance at edge N, first beat visible after edge N+LATENCY.
  - BURST
    - Beat k presents hc_addr_out = base + k*WORD_BYTES and hc_value_out = mem[index(that address)].
    - On transfer with k<BEATS-1: present beat k+1 the next cycle. No bubble when hc_ready_in is held at 1.
    - On transfer of beat BEATS-1: hc_valid_out=0 and go to IDLE. hc_ready_out returns to 1 the following cycle.
    - If hc_ready_in=0: hold the beat indefinitely.
- Out-of-range addresses wrap: the word index uses only WORD_IDX_BITS bits; upper address bits are ignored for storage but are echoed unchanged in hc_addr_out.
- Read-after-write: a write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Writes cannot overlap a burst, because ready is 0 outside IDLE. Requests presented then are stalled, not dropped.
- hc_value_in is ignored on reads. hc_we_in is sampled only on a transfer.

Decomposition:
- Shared package types (existing) gains:
  - dram_state_t enum: IDLE, WAIT_LAT, BURST.
  - Helper functions line_base(addr) and word_index(addr).
  - Default constants DRAM_LATENCY and DRAM_WORDS.
- One sub-module: dram_word_array. It is a single-port, W-bit x MEM_WORDS array with synchronous write and combinational read, indexed by word. The responder FSM instantiates it and registers the read data into hc_value_out.

Test Plan:
- Reset then idle: assert rst_in 2 cycles -> hc_valid_out=0, hc_addr_out=0, hc_value_out=0, hc_ready_out=1 on the first cycle after reset drops.
- Writes then line read: write words 0x100+8k = 0xA0+k for k=0..7, then read 0x108 with hc_ready_in=1 -> first beat exactly 4 cycles after acceptance; 8 consecutive beats with addr 0x100..0x138 and data 0xA0..0xA7; hc_ready_out=1 the cycle after the last beat.
- Backpressure: same read with hc_ready_in low for 3 cycles on beats 2 and 5 -> each beat's addr/value held stable while stalled; no beat lost or duplicated; total beats = 8.
- Wrap-around: write 0xDEAD at address MEM_WORDS*8 + 0x40, read 0x40 -> beat 0 data 0xDEAD; reading MEM_WORDS*8 + 0x40 returns hc_addr_out with upper bits preserved.
- Stall and read-after-write: present a write during BURST -> hc_ready_out=0 and the write is not applied until IDLE; a read of the same line issued immediately afterwards returns the new value.
- Reset mid-burst: assert rst_in after beat 3 transfers -> hc_valid_out=0 the next cycle, no further beats, and a new read returns the correct data.
